// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit state encoding.
// Also holds the byte bit-reversal helper used when sending the FCS.
package eth_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam int          MIN_LEN_DEF   = 60;
    localparam int          MAX_LEN_DEF   = 1514;
    localparam int          IFG_CYC_DEF   = 12;
    localparam int          PRE_CYC       = 7;

    typedef enum logic [2:0] {
        TX_IDLE, TX_PRE, TX_SFD, TX_DATA, TX_PAD, TX_FCS, TX_IFG, TX_FIN
    } tx_state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction
endpackage

// File: rtl/ethtransmit_ctl_if.sv
// Signal bundle between the transmit controller and its buffer, CRC generator,
// GMII TX pins and register block. master = controller side.
interface ethtransmit_ctl_if;
    logic        txena;
    logic        txrdy;
    logic [10:0] txcntb;
    logic [15:0] txbdata;
    logic [31:0] crc;
    logic [9:0]  txbaddr;
    logic [7:0]  dataout;
    logic        txen;
    logic        txer;
    logic        crcen;
    logic        crcre;
    logic        txbusy;
    logic        txdone;

    modport master (
        input  txena, txrdy, txcntb, txbdata, crc,
        output txbaddr, dataout, txen, txer, crcen, crcre, txbusy, txdone
    );
    modport slave (
        output txena, txrdy, txcntb, txbdata, crc,
        input  txbaddr, dataout, txen, txer, crcen, crcre, txbusy, txdone
    );
endinterface

// File: rtl/ethtransmit_ctl.sv
// GMII transmit controller: preamble/SFD, little-endian buffer data, zero padding,
// FCS from the shared CRC generator, inter-frame gap and txrdy/txdone handshake.
module ethtransmit_ctl
    import eth_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int IFG_CYC = IFG_CYC_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    ethtransmit_ctl_if.master bus
);
    localparam logic [10:0] L_MIN = 11'(MIN_LEN);
    localparam logic [10:0] L_MAX = 11'(MAX_LEN);
    localparam logic [10:0] L_IFG = 11'(IFG_CYC);
    localparam logic [10:0] L_PRE = 11'(PRE_CYC);

    tx_state_e   r_state;
    logic [10:0] r_cnt;
    logic [10:0] r_len;
    logic [7:0]  r_bufdat;
    logic [31:0] r_fcs;
    logic [9:0]  r_txbaddr;
    logic [7:0]  r_dataout;
    logic        r_txen;
    logic        r_crcen;
    logic        r_crcre;
    logic        r_txbusy;
    logic        r_txdone;

    logic [10:0] w_len;
    logic [31:0] w_fcs;
    logic [7:0]  w_byte;
    logic        w_more;
    logic        w_start;

    assign w_len   = (bus.txcntb > L_MAX) ? L_MAX : bus.txcntb;
    assign w_fcs   = ~bus.crc;
    // r_cnt is the index of the next data byte; odd bytes come from the held high half
    assign w_byte  = r_cnt[0] ? r_bufdat : bus.txbdata[7:0];
    // Advance the address only while a further word is still needed
    assign w_more  = ({1'b0, r_cnt} + 12'd2) < {1'b0, r_len};
    assign w_start = bus.txrdy && bus.txena && !r_txdone;

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_bufdat  <= '0;
            r_fcs     <= '0;
            r_txbaddr <= '0;
            r_dataout <= '0;
            r_txen    <= 1'b0;
            r_crcen   <= 1'b0;
            r_crcre   <= 1'b1;
            r_txbusy  <= 1'b0;
            r_txdone  <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_crcre   <= 1'b1;
                    r_crcen   <= 1'b0;
                    r_txen    <= 1'b0;
                    r_txbaddr <= '0;
                    r_dataout <= '0;
                    if (w_start) begin
                        r_len     <= w_len;
                        r_txbusy  <= 1'b1;
                        r_txen    <= 1'b1;
                        r_dataout <= PREAMBLE_BYTE;
                        r_cnt     <= 11'd1;
                        r_state   <= TX_PRE;
                    end
                end
                TX_PRE: begin
                    if (r_cnt == L_PRE) begin
                        r_dataout <= SFD_BYTE;
                        r_crcre   <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= TX_SFD;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                TX_SFD, TX_DATA: begin
                    if (r_cnt == r_len) begin
                        if (r_len < L_MIN) begin
                            r_dataout <= 8'h00;
                            r_crcen   <= 1'b1;
                            r_cnt     <= r_cnt + 11'd1;
                            r_state   <= TX_PAD;
                        end else begin
                            r_crcen   <= 1'b0;
                            r_dataout <= bitrev8(w_fcs[31:24]);
                            r_fcs     <= {w_fcs[23:0], 8'h00};
                            r_cnt     <= 11'd1;
                            r_state   <= TX_FCS;
                        end
                    end else begin
                        r_dataout <= w_byte;
                        r_crcen   <= 1'b1;
                        r_cnt     <= r_cnt + 11'd1;
                        r_state   <= TX_DATA;
                        if (!r_cnt[0]) begin
                            r_bufdat <= bus.txbdata[15:8];
                            if (w_more) r_txbaddr <= r_txbaddr + 10'd1;
                        end
                    end
                end
                TX_PAD: begin
                    if (r_cnt == L_MIN) begin
                        r_crcen   <= 1'b0;
                        r_dataout <= bitrev8(w_fcs[31:24]);
                        r_fcs     <= {w_fcs[23:0], 8'h00};
                        r_cnt     <= 11'd1;
                        r_state   <= TX_FCS;
                    end else begin
                        r_dataout <= 8'h00;
                        r_cnt     <= r_cnt + 11'd1;
                    end
                end
                TX_FCS: begin
                    if (r_cnt == 11'd4) begin
                        r_txen    <= 1'b0;
                        r_dataout <= '0;
                        r_crcre   <= 1'b1;
                        r_txbaddr <= '0;
                        r_cnt     <= 11'd1;
                        r_state   <= TX_IFG;
                    end else begin
                        r_dataout <= bitrev8(r_fcs[31:24]);
                        r_fcs     <= {r_fcs[23:0], 8'h00};
                        r_cnt     <= r_cnt + 11'd1;
                    end
                end
                TX_IFG: begin
                    if (r_cnt == L_IFG) begin
                        r_txbusy <= 1'b0;
                        r_txdone <= 1'b1;
                        r_state  <= TX_FIN;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                TX_FIN: begin
                    if (!bus.txrdy) begin
                        r_txdone <= 1'b0;
                        r_state  <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign bus.txbaddr = r_txbaddr;
    assign bus.dataout = r_dataout;
    assign bus.txen    = r_txen;
    assign bus.txer    = 1'b0;
    assign bus.crcen   = r_crcen;
    assign bus.crcre   = r_crcre;
    assign bus.txbusy  = r_txbusy;
    assign bus.txdone  = r_txdone;
endmodule

// File: tb/tb_ethtransmit_ctl.sv
// Directed bench for ethtransmit_ctl: buffer memory and normal-form CRC generator models,
// byte scoreboard built from a reflected CRC-32 reference, handshake, IFG and reset abort.
`timescale 1ns/1ps
module tb_ethtransmit_ctl;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #4 clk = ~clk;

    ethtransmit_ctl_if bus();

    ethtransmit_ctl #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_CYC(12)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:1023];
    logic [7:0]  exp_q [$];
    logic [7:0]  frm_q [$];
    int          txen_cyc = 0;
    int          low_run  = 1000;
    int          last_gap = 0;
    int          frames   = 0;
    int          peak     = 0;
    logic        prev_txen = 1'b0;

    function automatic logic [31:0] crc_norm_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[31] ^ d[k];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_refl_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer memory and shared CRC generator live on the PHY (rising) edge
    always @(posedge clk) bus.txbdata <= mem[bus.txbaddr];
    always @(posedge clk) begin
        if (bus.crcre)      bus.crc <= 32'hFFFFFFFF;
        else if (bus.crcen) bus.crc <= crc_norm_byte(bus.crc, bus.dataout);
    end

    always @(posedge clk) begin
        logic [7:0] b;
        if (bus.txen) begin
            if (!prev_txen) begin
                last_gap = low_run;
                txen_cyc = 0;
                frames++;
                peak = 0;
                frm_q.delete();
            end
            low_run = 0;
            txen_cyc++;
            frm_q.push_back(bus.dataout);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL txd_extra: observed byte %0h expected none", bus.dataout);
            end
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("txd", 32'(bus.dataout), 32'(b));
            end
        end else begin
            low_run++;
        end
        if (int'(bus.txbaddr) > peak) peak = int'(bus.txbaddr);
        prev_txen = bus.txen;
    end

    task automatic build_exp(input int len);
        int          eff;
        int          tot;
        logic [31:0] c;
        logic [7:0]  b;
        eff = (len > 1514) ? 1514 : len;
        tot = (eff < 60) ? 60 : eff;
        c = 32'hFFFFFFFF;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < tot; i++) begin
            if (i >= eff)  b = 8'h00;
            else if (i[0]) b = mem[i/2][15:8];
            else           b = mem[i/2][7:0];
            exp_q.push_back(b);
            c = crc_refl_byte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic run_frame(input int len, input string nm, input int hold);
        int          tot;
        int          cyc;
        int          f0;
        logic [31:0] res;
        tot = (len > 1514) ? 1514 : ((len < 60) ? 60 : len);
        build_exp(len);
        bus.txcntb = 11'(len);
        bus.txrdy  = 1'b1;
        cyc = 0;
        while (!bus.txdone && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk({nm, "_done_in_time"}, 32'(cyc < 4000), 32'd1);
        chk({nm, "_txen_cycles"}, 32'(txen_cyc), 32'(12 + tot));
        chk({nm, "_all_bytes_sent"}, 32'(exp_q.size()), 32'd0);
        res = 32'hFFFFFFFF;
        for (int i = 8; i < frm_q.size(); i++) res = crc_norm_byte(res, frm_q[i]);
        chk({nm, "_rx_residue"}, res, 32'hC704DD7B);
        chk({nm, "_rx_count"}, 32'(frm_q.size() - 12), 32'(tot));
        chk({nm, "_busy_at_done"}, 32'(bus.txbusy), 32'd0);
        if (hold > 0) begin
            f0 = frames;
            repeat (hold) tick();
            chk({nm, "_no_refire"}, 32'(frames), 32'(f0));
            chk({nm, "_done_held"}, 32'(bus.txdone), 32'd1);
        end
        bus.txrdy = 1'b0;
        tick();
        chk({nm, "_done_clear"}, 32'(bus.txdone), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int f0;
        for (int n = 0; n < 1024; n++) mem[n] = {8'(2*n + 1), 8'(2*n)};
        bus.txena  = 1'b0;
        bus.txrdy  = 1'b0;
        bus.txcntb = '0;
        clr_n      = 1'b0;
        repeat (3) tick();
        chk("rst_txen",    32'(bus.txen),    32'd0);
        chk("rst_dataout", 32'(bus.dataout), 32'd0);
        chk("rst_txbaddr", 32'(bus.txbaddr), 32'd0);
        chk("rst_crcen",   32'(bus.crcen),   32'd0);
        chk("rst_crcre",   32'(bus.crcre),   32'd1);
        chk("rst_txbusy",  32'(bus.txbusy),  32'd0);
        chk("rst_txdone",  32'(bus.txdone),  32'd0);
        chk("rst_txer",    32'(bus.txer),    32'd0);
        clr_n = 1'b1;
        bus.txena = 1'b1;
        repeat (3) tick();

        run_frame(64, "len64", 20);
        chk("len64_addr_peak", 32'(peak), 32'd31);

        run_frame(64, "b2b_a", 0);
        run_frame(64, "b2b_b", 0);
        chk("ifg_gap_ge12", 32'(last_gap >= 12), 32'd1);

        mem[0] = 16'hBBAA;
        mem[1] = 16'h00CC;
        bus.txena  = 1'b0;
        bus.txcntb = 11'd3;
        bus.txrdy  = 1'b1;
        f0 = frames;
        repeat (30) tick();
        chk("txena_blocks_busy",   32'(bus.txbusy), 32'd0);
        chk("txena_blocks_frames", 32'(frames),     32'(f0));
        bus.txena = 1'b1;
        run_frame(3, "len3", 5);

        for (int n = 0; n < 1024; n++) mem[n] = {8'(2*n + 1), 8'(2*n)};
        run_frame(2000, "len2000", 5);
        chk("len2000_addr_peak", 32'(peak), 32'd756);

        build_exp(64);
        bus.txcntb = 11'd64;
        bus.txrdy  = 1'b1;
        f0 = frames;
        cyc = 0;
        while (!(frames == f0 + 1 && txen_cyc >= 29) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("abort_reached_data", 32'(cyc < 200), 32'd1);
        chk("abort_crcen_in_data", 32'(bus.crcen), 32'd1);
        #1 clr_n = 1'b0;
        #1;
        chk("abort_txen_async",   32'(bus.txen),   32'd0);
        chk("abort_txbusy_async", 32'(bus.txbusy), 32'd0);
        bus.txrdy = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        clr_n = 1'b1;
        repeat (10) tick();
        chk("abort_idle_txen",   32'(bus.txen),  32'd0);
        chk("abort_idle_crcre",  32'(bus.crcre), 32'd1);
        chk("abort_no_restart",  32'(frames),    32'(f0 + 1));
        run_frame(64, "restart", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
